multicast_demux: RTL and testbench

- Egress-side fan-out engine of the 7-port crossbar switch; complement of the priority/reduction merge unit.
- Accepts one packet stream and routes each packet to one or more of seven output ports (local, yneg, ypos, xpos, xneg, zpos, zneg).
- Unicast packets go to the port named in their exit field.
- Multicast packets are replicated per a programmable multicast table. Each copy carries its own port index in the exit field.

---
 rtl/multicast_demux.sv | 176 +++++++++++++++++
 tb/tb_multicast_demux.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_demux.sv
// multicast_demux: egress fan-out engine; routes each packet to one or more of 7 ports,
// replicating multicast packets per a programmable table (exit field rewritten per copy).
// Latency 3 cycles input-to-output (FIFO write, lookup, send); throughput 1 packet / 3 cycles.
// Backpressure: in_avail drops when the input FIFO is full; stalled ports hold their copy pending.
// Ports: clk/rst (async active-low), in/in_avail (packet input), tbl_wr_* (table programming),
//        out_stall (per-port stall), out_0..out_6/send (per-port packet pulses), busy, drop_cnt.
// Optional: define MULTICAST_DROP_CNT_EN to count dropped packets on drop_cnt (else tied to 0).
module multicast_demux #(
  parameter int DataWidth       = 256,
  parameter int MulticastBitPos = 253,
  parameter int IndexPos        = 128,
  parameter int IndexWidth      = 8,
  parameter int ExitPos         = 160,
  parameter int ExitWidth       = 4,
  parameter int InFIFODepth     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  in,
  output logic                  in_avail,
  input  logic                  tbl_wr_en,
  input  logic [IndexWidth-1:0] tbl_wr_addr,
  input  logic [6:0]            tbl_wr_data,
  input  logic [6:0]            out_stall,
  output logic [DataWidth-1:0]  out_0,
  output logic [DataWidth-1:0]  out_1,
  output logic [DataWidth-1:0]  out_2,
  output logic [DataWidth-1:0]  out_3,
  output logic [DataWidth-1:0]  out_4,
  output logic [DataWidth-1:0]  out_5,
  output logic [DataWidth-1:0]  out_6,
  output logic [6:0]            send,
  output logic                  busy,
  output logic [15:0]           drop_cnt
);

  localparam int NumPorts = 7;
  localparam int PtrW     = $clog2(InFIFODepth);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_e;

  // Input FIFO
  logic [DataWidth-1:0] fifo_mem_q [InFIFODepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 push, pop;

  // Engine state
  state_e               state_q;
  logic [DataWidth-1:0] hold_q;
  logic [6:0]           tbl_rd_q;
  logic [6:0]           pending_q;
  logic [6:0]           pending_d;
  logic [DataWidth-1:0] out_q [NumPorts];
  logic [DataWidth-1:0] copy  [NumPorts];
  logic [6:0]           lookup_mask;
  logic [6:0]           fire;
  logic [ExitWidth-1:0] exit_val;
  logic [DataWidth-1:0] head;

  // Multicast table: not reset, contents survive rst
  logic [6:0] tbl_q [2**IndexWidth];

  // Fullness comes from the registered count, so a push and pop at full still sees "full".
  assign in_avail = (count_q != (PtrW+1)'(InFIFODepth));
  assign push     = in[DataWidth-1] & in_avail;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
  end

  // Old entry is returned on a same-address read/write because both are registered.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) tbl_q[tbl_wr_addr] <= tbl_wr_data;
  end

  // Unicast exit beyond the last port yields an empty mask, which means drop.
  always_comb begin
    exit_val    = hold_q[ExitPos +: ExitWidth];
    lookup_mask = '0;
    if (hold_q[MulticastBitPos])
      lookup_mask = tbl_rd_q;
    else if (32'(exit_val) < NumPorts)
      lookup_mask = 7'd1 << exit_val;
  end

  assign fire      = pending_q & ~out_stall;
  assign pending_d = pending_q & out_stall;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      copy[p] = hold_q;
      copy[p][ExitPos +: ExitWidth] = ExitWidth'(p);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      tbl_rd_q  <= '0;
      pending_q <= '0;
      for (int p = 0; p < NumPorts; p++) out_q[p] <= '0;
    end else begin
      // Outputs default to zero so every copy is a one-cycle pulse.
      for (int p = 0; p < NumPorts; p++) out_q[p] <= '0;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            hold_q   <= head;
            tbl_rd_q <= tbl_q[head[IndexPos +: IndexWidth]];
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          pending_q <= lookup_mask;
          state_q   <= (lookup_mask == '0) ? IDLE : SEND;
        end
        SEND: begin
          for (int p = 0; p < NumPorts; p++)
            if (fire[p]) out_q[p] <= copy[p];
          pending_q <= pending_d;
          if (pending_d == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULTICAST_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop_event;

  assign drop_event = (state_q == LOOKUP) && (lookup_mask == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt_q <= '0;
    else if (drop_event && (drop_cnt_q != 16'hFFFF))
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  always_comb begin
    send = '0;
    for (int p = 0; p < NumPorts; p++) send[p] = out_q[p][DataWidth-1];
  end

  assign busy  = (state_q != IDLE) || (count_q != '0);
  assign out_0 = out_q[0];
  assign out_1 = out_q[1];
  assign out_2 = out_q[2];
  assign out_3 = out_q[3];
  assign out_4 = out_q[4];
  assign out_5 = out_q[5];
  assign out_6 = out_q[6];

endmodule

// File: tb/tb_multicast_demux.sv
// tb_multicast_demux: scoreboard bench for multicast_demux.
// Main process drives packets and records expected fan-out; monitor checks every output pulse.
// Random phase uses random stalls, unicast/multicast mix and drops.
module tb_multicast_demux;

  localparam int DW = 256;
  localparam int MCB = 253;
  localparam int IXP = 128;
  localparam int EXP = 160;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [6:0]    mask;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in;
  logic          in_avail;
  logic          tbl_wr_en;
  logic [7:0]    tbl_wr_addr;
  logic [6:0]    tbl_wr_data;
  logic [6:0]    out_stall;
  logic [DW-1:0] outs [7];
  logic [6:0]    send;
  logic          busy;
  logic [15:0]   drop_cnt;

  int   vectors = 0;
  int   errors  = 0;
  int   model_drops = 0;
  bit   rand_stall = 0;
  pkt_t exp_q[$];
  logic [6:0] tbl_model [256];

  always #5 clk = ~clk;

  multicast_demux dut (
    .clk(clk), .rst(rst), .in(in), .in_avail(in_avail),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .out_stall(out_stall),
    .out_0(outs[0]), .out_1(outs[1]), .out_2(outs[2]), .out_3(outs[3]),
    .out_4(outs[4]), .out_5(outs[5]), .out_6(outs[6]),
    .send(send), .busy(busy), .drop_cnt(drop_cnt)
  );

  // Monitor: every pulse must belong to the oldest packet with copies outstanding.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      for (int p = 0; p < 7; p++) begin
        if (send[p] || outs[p][DW-1]) begin
          pkt_t h;
          logic [DW-1:0] e;
          vectors++;
          if (send[p] !== outs[p][DW-1]) begin
            errors++;
            $display("FAIL send_vs_valid port%0d: send=%b valid=%b", p, send[p], outs[p][DW-1]);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_copy port%0d: got %h, required no output", p, outs[p]);
          end else begin
            h = exp_q[0];
            e = h.data;
            e[EXP +: 4] = 4'(p);
            if (!h.mask[p]) begin
              errors++;
              $display("FAIL order port%0d: got %h, head packet mask %b does not include port", p, outs[p], h.mask);
            end else if (outs[p] !== e) begin
              errors++;
              $display("FAIL copy_data port%0d: got %h required %h", p, outs[p], e);
            end
            h.mask[p] = 1'b0;
            exp_q[0] = h;
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].mask == 7'd0) void'(exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_stall) begin
      #2;
      out_stall = 7'($urandom) & 7'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk_pkt(input bit mc, input logic [7:0] idx, input logic [3:0] ex);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    d[DW-1]     = 1'b1;
    d[MCB]      = mc;
    d[IXP +: 8] = idx;
    d[EXP +: 4] = ex;
    return d;
  endfunction

  // Reference routing: multicast uses the table, unicast one-hot of exit, empty = drop.
  task automatic model_issue(input logic [DW-1:0] d);
    logic [6:0] m;
    int ex;
    ex = int'(d[EXP +: 4]);
    if (d[MCB]) m = tbl_model[d[IXP +: 8]];
    else if (ex <= 6) m = 7'(2 ** ex);
    else m = 7'd0;
    if (m == 7'd0) model_drops++;
    else exp_q.push_back({d, m});
  endtask

  task automatic write_tbl(input logic [7:0] a, input logic [6:0] m);
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = m;
    tick();
    tbl_wr_en = 1'b0;
    tbl_model[a] = m;
  endtask

  task automatic push_pkt(input logic [DW-1:0] d);
    int w = 0;
    while (!in_avail && w < 2000) begin tick(); w++; end
    if (!in_avail) begin
      vectors++; errors++;
      $display("FAIL in_avail_timeout: in_avail=0 after %0d cycles, required 1", w);
    end else begin
      model_issue(d);
      in = d;
      tick();
      in = '0;
    end
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 5000) begin tick(); w++; end
    tick(); tick();
    vectors++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d busy=%b, required 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic chk_drops(input string name);
    int req;
`ifdef MULTICAST_DROP_CNT_EN
    req = model_drops;
`else
    req = 0;
`endif
    chk(name, DW'(drop_cnt), DW'(req));
  endtask

  initial begin
    logic [DW-1:0] pa, pb;
    rst = 1'b1; in = '0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0; out_stall = '0;
    #3 rst = 1'b0;
    tick(); tick();
    chk("reset_send", DW'(send), '0);
    chk("reset_busy", DW'(busy), '0);
    chk("reset_drop_cnt", DW'(drop_cnt), '0);
    chk("reset_in_avail", DW'(in_avail), DW'(1));
    chk("reset_out3", outs[3], '0);
    rst = 1'b1;
    tick();

    // 1: unicast exit 3, exact latency
    pa = mk_pkt(0, 8'h05, 4'd3);
    model_issue(pa);
    in = pa;
    tick(); in = '0;               // edge 0 sampled the packet
    tick(); tick();                // edges 1, 2
    chk("t1_send_before", DW'(send), '0);
    chk("t1_busy_during", DW'(busy), DW'(1));
    tick();                        // edge 3
    chk("t1_send", DW'(send), DW'(7'b0001000));
    chk("t1_out3", outs[3], pa);
    chk("t1_busy_after", DW'(busy), '0);
    drain("t1");

    // 2: multicast to four ports in one cycle
    write_tbl(8'h05, 7'b1010101);
    pa = mk_pkt(1, 8'h05, 4'd9);
    model_issue(pa);
    in = pa;
    tick(); in = '0;
    tick(); tick(); tick();
    chk("t2_send", DW'(send), DW'(7'b1010101));
    tick();
    chk("t2_send_pulse", DW'(send), '0);
    drain("t2");

    // 3: port 2 stalled; following unicast to port 0 must wait
    out_stall = 7'b0000100;
    pa = mk_pkt(1, 8'h05, 4'd1);
    pb = mk_pkt(0, 8'h05, 4'd0);
    model_issue(pa);
    in = pa;
    tick();
    model_issue(pb);
    in = pb;
    tick(); in = '0;
    tick(); tick();                // edge 3
    chk("t3_send_first", DW'(send), DW'(7'b1010001));
    tick();
    chk("t3_send_stalled", DW'(send), '0);
    out_stall = '0;
    tick();
    chk("t3_send_port2", DW'(send), DW'(7'b0000100));
    drain("t3");

    // 4: fill FIFO and hold register under full stall
    out_stall = 7'h7F;
    for (int i = 0; i < 5; i++) push_pkt(mk_pkt(0, 8'h05, 4'($urandom_range(0, 6))));
    tick(); tick();
    chk("t4_in_avail_full", DW'(in_avail), '0);
    chk("t4_no_send", DW'(send), '0);
    out_stall = '0;
    push_pkt(mk_pkt(0, 8'h05, 4'($urandom_range(0, 6))));
    drain("t4");

    // 5: drops
    write_tbl(8'h20, 7'b0);
    push_pkt(mk_pkt(0, 8'h05, 4'd9));
    push_pkt(mk_pkt(1, 8'h20, 4'd2));
    drain("t5");
    chk_drops("t5_drop_cnt");

    // Random phase
    for (int i = 0; i < 16; i++)
      write_tbl(8'h40 + 8'(i), (i == 0) ? 7'd0 : 7'($urandom));
    rand_stall = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1)
        pa = mk_pkt(1, 8'h40 + 8'($urandom_range(0, 15)), 4'($urandom));
      else
        pa = mk_pkt(0, 8'($urandom), 4'($urandom_range(0, 9)));
      push_pkt(pa);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain("random");
    rand_stall = 1'b0;
    tick(); tick();
    out_stall = '0;
    chk_drops("random_drop_cnt");

    // 6: reset in the middle of SEND
    out_stall = 7'b1000000;
    pa = mk_pkt(1, 8'h05, 4'd0);
    model_issue(pa);
    in = pa;
    tick(); in = '0;
    tick(); tick(); tick();
    chk("t6_send_partial", DW'(send), DW'(7'b0010101));
    rst = 1'b0;
    model_drops = 0;
    #1;
    chk("t6_rst_send", DW'(send), '0);
    chk("t6_rst_out0", outs[0], '0);
    chk("t6_rst_busy", DW'(busy), '0);
    chk("t6_rst_drop_cnt", DW'(drop_cnt), '0);
    tick(); tick();
    rst = 1'b1;
    out_stall = '0;
    tick();
    push_pkt(mk_pkt(1, 8'h05, 4'd3));
    drain("t6");
    chk_drops("t6_drop_cnt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
